// File: rtl/lut_table_loader_pkg.sv
// Shared types and sizing helpers for the LUT-neuron table writer and the
// neuron-table memory it feeds.
package lut_cfg_pkg;

    // Defaults shared with the neuron-table memory instance.
    localparam int DEF_IN_BITS     = 6;
    localparam int DEF_OUT_BITS    = 1;
    localparam int DEF_NUM_NEURONS = 128;
    localparam int DEF_CFG_W       = 8;
    localparam int CFG_ID_W        = 8;   // stream-side neuron id width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } lut_cfg_state_e;

    // Width of one neuron's full truth table.
    function automatic int tbl_w(input int in_bits, input int out_bits);
        return (1 << in_bits) * out_bits;
    endfunction

    // Stream beats needed to carry one truth table.
    function automatic int beats(input int in_bits, input int out_bits, input int cfg_w);
        return tbl_w(in_bits, out_bits) / cfg_w;
    endfunction

endpackage

// File: rtl/lut_table_loader_if.sv
// Configuration stream plus table-write bus of the LUT table loader.
// master = stream source / table memory side, slave = the loader.
interface lut_table_loader_if
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int CFG_W       = DEF_CFG_W
);
    localparam int TBL_W = tbl_w(IN_BITS, OUT_BITS);
    localparam int ID_W  = $clog2(NUM_NEURONS);

    // configuration byte stream
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic [CFG_ID_W-1:0] cfg_id;
    logic                cfg_last;

    // table memory write port and status
    logic                tbl_we;
    logic [ID_W-1:0]     tbl_addr;
    logic [TBL_W-1:0]    tbl_data;
    logic                done;
    logic                err;
    logic                busy;

    modport master (
        output cfg_valid, cfg_data, cfg_id, cfg_last,
        input  cfg_ready, tbl_we, tbl_addr, tbl_data, done, err, busy
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_id, cfg_last,
        output cfg_ready, tbl_we, tbl_addr, tbl_data, done, err, busy
    );

endinterface

// File: rtl/lut_frame_packer.sv
// Beat counter plus indexed beat write into the staging table register.
// clear restarts the frame (and may coincide with wr for beat 0); the
// counter saturates at BEATS so over-long frames never wrap onto slot 0.
module lut_frame_packer #(
    parameter int TBL_W = 64,
    parameter int CFG_W = 8,
    parameter int BEATS = TBL_W / CFG_W,
    parameter int CNT_W = $clog2(BEATS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr,
    input  logic [CFG_W-1:0] din,
    output logic             full,
    output logic [TBL_W-1:0] word_nxt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TBL_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] base_cnt;

    // Next beat slot and staging word; the write lands in the slot chosen by
    // the count as it stands after an optional clear.
    always_comb begin
        base_cnt = clear ? '0 : cnt_q;
        cnt_d    = base_cnt;
        word_d   = clear ? '0 : word_q;
        if (wr) begin
            for (int b = 0; b < BEATS; b++) begin
                if (base_cnt == CNT_W'(b))
                    word_d[b*CFG_W +: CFG_W] = din;
            end
            if (base_cnt != CNT_W'(BEATS))
                cnt_d = base_cnt + CNT_W'(1);
        end
    end

    // Counter and staging register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // full: the next accepted beat fills the last slot of the table.
    assign full     = (cnt_q == CNT_W'(BEATS - 1));
    // word_nxt includes the beat being written this cycle, so the top can
    // capture a completed table on the same edge as the final beat.
    assign word_nxt = word_d;

endmodule

// File: rtl/lut_table_loader.sv
// Runtime writer for LUT-neuron truth tables: collects one table per
// valid/ready frame and commits it with a single-cycle write strobe.
// Parameters must match those of the connected lut_table_loader_if.
module lut_table_loader
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int CFG_W       = DEF_CFG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_table_loader_if.slave bus
);

    localparam int TBL_W = tbl_w(IN_BITS, OUT_BITS);
    localparam int BEATS = beats(IN_BITS, OUT_BITS, CFG_W);
    localparam int ID_W  = $clog2(NUM_NEURONS);

    lut_cfg_state_e   state_q, state_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  tbl_addr_q, tbl_addr_d;
    logic [TBL_W-1:0] tbl_data_q, tbl_data_d;

    logic             acc;
    logic             id_bad;
    logic             pk_clear, pk_wr, pk_full;
    logic [TBL_W-1:0] pk_word_nxt;

    assign acc    = bus.cfg_valid && cfg_ready_q;
    assign id_bad = (32'(bus.cfg_id) >= 32'(NUM_NEURONS));

    lut_frame_packer #(
        .TBL_W (TBL_W),
        .CFG_W (CFG_W),
        .BEATS (BEATS)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (pk_clear),
        .wr       (pk_wr),
        .din      (bus.cfg_data),
        .full     (pk_full),
        .word_nxt (pk_word_nxt)
    );

    // Frame FSM: next state, packer controls, and commit-time capture of
    // address/data so the write port only changes when a table is committed.
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        id_d       = id_q;
        tbl_addr_d = tbl_addr_q;
        tbl_data_d = tbl_data_q;
        pk_clear   = 1'b0;
        pk_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    pk_clear = 1'b1;
                    pk_wr    = 1'b1;
                    id_d     = bus.cfg_id[ID_W-1:0];
                    if (bus.cfg_last) begin
                        // single-beat frame: only complete if the table is one beat
                        if (id_bad || BEATS > 1) begin
                            err_d = 1'b1;
                        end else begin
                            state_d    = COMMIT;
                            tbl_addr_d = bus.cfg_id[ID_W-1:0];
                            tbl_data_d = pk_word_nxt;
                        end
                    end else if (id_bad || BEATS == 1) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (acc) begin
                    pk_wr = 1'b1;
                    if (pk_full) begin
                        if (bus.cfg_last) begin
                            state_d    = COMMIT;
                            tbl_addr_d = id_q;
                            tbl_data_d = pk_word_nxt;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (bus.cfg_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // swallow the rest of a bad frame; packer count saturates
                if (acc) begin
                    pk_wr = 1'b1;
                    if (bus.cfg_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is registered: held low only for the commit cycle.
    always_comb begin
        cfg_ready_d = (state_d != COMMIT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b0;
            err_q       <= 1'b0;
            id_q        <= '0;
            tbl_addr_q  <= '0;
            tbl_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            err_q       <= err_d;
            id_q        <= id_d;
            tbl_addr_q  <= tbl_addr_d;
            tbl_data_q  <= tbl_data_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.tbl_we    = (state_q == COMMIT);
    assign bus.done      = (state_q == COMMIT);
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tbl_addr  = tbl_addr_q;
    assign bus.tbl_data  = tbl_data_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: frame-level model checked every cycle,
// plus literal expectations on the committed writes and error pulses.
module tb_lut_table_loader;

    logic clk;
    logic rst_n;

    lut_table_loader_if bus ();

    lut_table_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Tracks an open frame (beats seen, id from first beat, bytes so far);
    // on the last beat the frame is good only if it had exactly 8 beats and
    // a valid id.
    logic        m_ready, m_we, m_err, m_busy, m_open;
    logic [6:0]  m_addr;
    logic [63:0] m_data, m_word;
    int          m_n;
    logic [7:0]  m_id;

    logic        nx_acc, nx_we, nx_err, nx_busy;
    int          nx_k;
    logic [7:0]  nx_id;
    logic [63:0] nx_w;

    always @* begin
        nx_acc  = bus.cfg_valid && m_ready;
        nx_we   = 1'b0;
        nx_err  = 1'b0;
        nx_k    = m_open ? m_n : 0;
        nx_id   = m_open ? m_id : bus.cfg_id;
        nx_w    = m_open ? m_word : 64'd0;
        if (nx_k < 8) nx_w[nx_k*8 +: 8] = bus.cfg_data;
        if (nx_acc && bus.cfg_last) begin
            if (nx_k == 7 && nx_id < 8'd128) nx_we = 1'b1;
            else                             nx_err = 1'b1;
        end
        nx_busy = nx_acc ? (!bus.cfg_last || nx_we) : m_open;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0; m_we <= 1'b0; m_err <= 1'b0; m_busy <= 1'b0;
            m_open  <= 1'b0; m_addr <= '0; m_data <= '0; m_word <= '0;
            m_n     <= 0;    m_id <= '0;
        end else begin
            if (nx_acc) begin
                if (bus.cfg_last) begin
                    m_open <= 1'b0;
                    if (nx_we) begin
                        m_addr <= nx_id[6:0];
                        m_data <= nx_w;
                    end
                end else begin
                    m_open <= 1'b1;
                    m_n    <= nx_k + 1;
                    m_id   <= nx_id;
                    m_word <= nx_w;
                end
            end
            m_we    <= nx_we;
            m_err   <= nx_err;
            m_ready <= !nx_we;
            m_busy  <= nx_busy;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit checking = 1'b0;
    always @(negedge clk) begin
        if (checking) begin
            chk("cfg_ready", 64'(bus.cfg_ready), 64'(m_ready));
            chk("tbl_we",    64'(bus.tbl_we),    64'(m_we));
            chk("done",      64'(bus.done),      64'(m_we));
            chk("err",       64'(bus.err),       64'(m_err));
            chk("busy",      64'(bus.busy),      64'(m_busy));
            chk("tbl_addr",  64'(bus.tbl_addr),  64'(m_addr));
            chk("tbl_data",  bus.tbl_data,       m_data);
        end
    end

    // ---------------- write / error log ----------------
    logic [6:0]  log_addr[$];
    logic [63:0] log_data[$];
    int          err_seen = 0;
    always @(negedge clk) begin
        if (bus.tbl_we) begin
            log_addr.push_back(bus.tbl_addr);
            log_data.push_back(bus.tbl_data);
        end
        if (bus.err) err_seen <= err_seen + 1;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends n beats; byte k comes from pat_lo/pat_hi (byte 0 lowest). The id
    // is only meaningful on the first beat, so later beats carry junk.
    task automatic send_frame(input logic [7:0] id, input int n, input logic [63:0] pat_lo,
                              input logic [63:0] pat_hi, input bit with_last, input bit gaps);
        int guard;
        int g;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    bus.cfg_valid = 1'b0;
                    repeat (g) @(negedge clk);
                end
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_id    = (k == 0) ? id : 8'hEE;
            if (k < 8) bus.cfg_data = pat_lo[k*8 +: 8];
            else       bus.cfg_data = pat_hi[(k-8)*8 +: 8];
            bus.cfg_last  = with_last && (k == n - 1);
            guard = 0;
            while (!bus.cfg_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_accept: got ready=0 for 50 cycles expected ready=1 (id %0d beat %0d)", id, k);
            end
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [6:0]  ea [6];
        logic [63:0] ed [6];
        ea = '{7'd122, 7'd3, 7'd127, 7'd0, 7'd1, 7'd5};
        ed = '{64'h33333333_FFFFFFFF, 64'h01234567_89ABCDEF, 64'hDEADBEEF_CAFEF00D,
               64'hA5A5A5A5_5A5A5A5A, 64'h0F1E2D3C_4B5A6978, 64'h11223344_55667788};

        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_id    = '0;
        bus.cfg_last  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checking = 1'b1;
        chk("rst_ready", 64'(bus.cfg_ready), 64'd0);
        chk("rst_addr",  64'(bus.tbl_addr),  64'd0);
        chk("rst_data",  bus.tbl_data,       64'd0);
        chk("rst_busy",  64'(bus.busy),      64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.cfg_ready), 64'd1);

        // nominal
        send_frame(8'd122, 8, 64'h33333333_FFFFFFFF, 64'd0, 1'b1, 1'b0);
        idle(3);
        // short frame, then good frame to id 3
        send_frame(8'd9, 5, 64'h0706050403020100, 64'd0, 1'b1, 1'b0);
        send_frame(8'd3, 8, 64'h01234567_89ABCDEF, 64'd0, 1'b1, 1'b0);
        idle(2);
        // long frame
        send_frame(8'd4, 10, 64'h1111111111111111, 64'h2222, 1'b1, 1'b0);
        idle(2);
        // bad id, then id 127 immediately
        send_frame(8'd200, 8, 64'h9999999999999999, 64'd0, 1'b1, 1'b0);
        send_frame(8'd127, 8, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b1, 1'b0);
        idle(2);
        // bubbles across two back-to-back frames
        send_frame(8'd0, 8, 64'hA5A5A5A5_5A5A5A5A, 64'd0, 1'b1, 1'b1);
        send_frame(8'd1, 8, 64'h0F1E2D3C_4B5A6978, 64'd0, 1'b1, 1'b1);
        idle(2);
        // reset mid-frame after 5 beats
        send_frame(8'd7, 5, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy",  64'(bus.busy),      64'd0);
        chk("midrst_ready", 64'(bus.cfg_ready), 64'd0);
        chk("midrst_data",  bus.tbl_data,       64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'd5, 8, 64'h11223344_55667788, 64'd0, 1'b1, 1'b0);
        idle(3);

        chk("write_count", 64'(log_addr.size()), 64'd6);
        chk("err_count",   64'(err_seen),        64'd3);
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                chk($sformatf("write%0d_addr", i), 64'(log_addr[i]), 64'(ea[i]));
                chk($sformatf("write%0d_data", i), log_data[i], ed[i]);
            end
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
